vertical_avg_filter: RTL and testbench
======================================

// Module: vertical_avg_filter
// PURPOSE
//  Streaming 2-tap vertical smoothing stage between image_read and image_write.
//  Consumes the image_read pixel-pair stream (two RGB888 pixels per valid cycle) and
//  emits the same stream format: each pixel is averaged with the pixel directly above it.
//  A one-row line buffer holds the previous row. Output drives image_write unchanged.
// PARAMETERS
//  WIDTH   768  image width in pixels (even); row = WIDTH/2 pixel pairs
//  HEIGHT  512  image height in rows
//  ROUND   1    1: avg=(a+b+1)>>1, 0: avg=(a+b)>>1
// PORTS
//  HCLK       in   1  clock, all logic on rising edge
//  HRESET     in   1  asynchronous, active-high reset
//  VSYNC_IN   in   1  frame-start pulse; high cycle forces counters to row 0, col 0
//  HSYNC_IN   in   1  pixel-pair valid; DATA_*_IN sampled when high
//  EN         in   1  1: filter, 0: bypass; sampled with each pair
//  DATA_R0_IN/G0/B0, DATA_R1_IN/G1/B1  in  8 each  even/odd pixel of pair
//  VSYNC_OUT  out  1  VSYNC_IN delayed 2 cycles
//  HSYNC_OUT  out  1  output pair valid (HSYNC_IN delayed 2 cycles)
//  DATA_R0/G0/B0/R1/G1/B1  out  8 each  filtered pair; 0 when HSYNC_OUT low
//  FRAME_DONE out  1  one-cycle pulse with the output of the last pair of a frame
// BEHAVIOUR
//  Reset: all outputs 0, col/row counters 0, pipeline valids 0; line buffer not cleared.
//  Stream: raster order, WIDTH/2 pairs per row, no backpressure; gaps (HSYNC_IN=0) allowed
//   anywhere, counters advance only on valid pairs.
//  Counters: col 0..WIDTH/2-1, wraps to 0 and row++; row wraps HEIGHT-1 -> 0 (next pair
//   is row 0 of a new frame). VSYNC_IN=1 sets col=row=0 for the pair in that same cycle
//   (if HSYNC_IN=1 it is pair 0 of row 0); partial row discarded.
//  Line buffer: WIDTH/2 x 48b, addr=col. Stage 1 (cycle 1): registered read of prev[col],
//   write of current pair to [col] in same cycle (read-before-write, old data returned).
//   Stage 2 (cycle 2): per-channel 9-bit sum, avg=(cur+prev+ROUND)>>1, registered out.
//  Row 0 or EN=0: output = current pair unmodified. Buffer still written in both cases.
//  Latency: exactly 2 HCLK from HSYNC_IN/data to HSYNC_OUT/data, including bypass.
//  FRAME_DONE: 1 when output pair is row HEIGHT-1, col WIDTH/2-1; aligned with HSYNC_OUT.
//  Reset mid-frame: in-flight pairs dropped (HSYNC_OUT low next cycles); next valid pair
//   treated as row 0 col 0.
//  Sums never overflow (9b); no saturation needed. Max avg 255 (255+255+1)>>1.
// TESTING (bench params WIDTH=4, HEIGHT=3, ROUND=1)
//  1 Reset: hold HRESET 3 cycles -> all outputs 0; release with HSYNC_IN=0 -> outputs stay 0.
//  2 Row 0 pass-through: 2 pairs all channels 0x40 -> 2 cycles later same 0x40 values,
//    HSYNC_OUT high exactly 2 cycles.
//  3 Average: row 0 all 0x10, row 1 all 0x21 -> row 1 outputs 0x19 ((0x10+0x21+1)>>1);
//    ROUND=0 rerun -> 0x18. Row 0 0xFF, row 1 0xFF -> 0xFF.
//  4 Frame wrap/FRAME_DONE: 6 pairs (3 rows) -> FRAME_DONE single pulse with 6th output;
//    7th pair passes through unaveraged (new row 0).
//  5 VSYNC mid-row and gaps: 1 pair of row 1, VSYNC_IN with next pair, idle cycles between
//    -> that pair output unmodified, counters restart; gaps produce HSYNC_OUT=0, data 0.
//  6 EN=0 on row 1 pair 0 only -> that pair bypassed, pair 1 averaged; reset asserted
//    mid-row 1 -> no HSYNC_OUT for dropped pairs, next pair output unmodified.

Source files
------------

// File: rtl/vertical_avg_filter.sv
// vertical_avg_filter: 2-tap vertical smoothing of an RGB888 pixel-pair stream.
// Each pixel is averaged with the pixel directly above it, using a one-row line
// buffer that holds the previous row. Row 0 and EN=0 pairs pass through unmodified.
// The latency is a fixed two clocks in every mode.
module vertical_avg_filter #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int ROUND  = 1
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       VSYNC_IN,
    input  logic       HSYNC_IN,
    input  logic       EN,
    input  logic [7:0] DATA_R0_IN,
    input  logic [7:0] DATA_G0_IN,
    input  logic [7:0] DATA_B0_IN,
    input  logic [7:0] DATA_R1_IN,
    input  logic [7:0] DATA_G1_IN,
    input  logic [7:0] DATA_B1_IN,
    output logic       VSYNC_OUT,
    output logic       HSYNC_OUT,
    output logic [7:0] DATA_R0,
    output logic [7:0] DATA_G0,
    output logic [7:0] DATA_B0,
    output logic [7:0] DATA_R1,
    output logic [7:0] DATA_G1,
    output logic [7:0] DATA_B1,
    output logic       FRAME_DONE
);

    localparam int PAIRS = WIDTH / 2;
    localparam int COL_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(PAIRS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
    localparam logic [8:0] ROUND_ADD = (ROUND != 0) ? 9'd1 : 9'd0;

    // Position counters: where the next valid pair lands in the frame.
    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;

    // Stage 1: captured pair, registered line-buffer read and side-band flags.
    logic        s1_valid_q, s1_valid_d;
    logic        s1_vsync_q, s1_vsync_d;
    logic        s1_bypass_q, s1_bypass_d;
    logic        s1_last_q, s1_last_d;
    logic [47:0] s1_cur_q, s1_cur_d;
    logic [47:0] prev_q, prev_d;

    // Stage 2: output registers.
    logic        hsync_out_q, hsync_out_d;
    logic        vsync_out_q, vsync_out_d;
    logic        done_q, done_d;
    logic [47:0] data_out_q, data_out_d;

    logic [47:0] cur_pair;
    logic [47:0] avg_pair;
    logic [8:0]  chan_sum;

    // One 48-bit word per pair of the previous row, indexed by column; never reset.
    logic [47:0] line_buf [PAIRS];

    assign cur_pair = {DATA_R0_IN, DATA_G0_IN, DATA_B0_IN,
                       DATA_R1_IN, DATA_G1_IN, DATA_B1_IN};

    // Position of the incoming pair (VSYNC forces row 0 col 0 in the same cycle) and the advance to the next one.
    always_comb begin
        col_cur = VSYNC_IN ? '0 : col_q;
        row_cur = VSYNC_IN ? '0 : row_q;
        col_d   = col_cur;
        row_d   = row_cur;
        if (HSYNC_IN) begin
            if (col_cur == LAST_COL) begin
                col_d = '0;
                row_d = (row_cur == LAST_ROW) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    // Position counter registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Stage 1 capture: data, filter bypass decision and end-of-frame marker.
    always_comb begin
        s1_valid_d  = HSYNC_IN;
        s1_vsync_d  = VSYNC_IN;
        s1_bypass_d = (row_cur == '0) || !EN;
        s1_last_d   = (row_cur == LAST_ROW) && (col_cur == LAST_COL);
        s1_cur_d    = cur_pair;
        prev_d      = line_buf[col_cur];
    end

    // Stage 1 registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_valid_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_cur_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_vsync_q  <= s1_vsync_d;
            s1_bypass_q <= s1_bypass_d;
            s1_last_q   <= s1_last_d;
            s1_cur_q    <= s1_cur_d;
        end
    end

    // Line buffer: the read sees the old word while the current pair overwrites it.
    always_ff @(posedge HCLK) begin
        prev_q <= prev_d;
        if (HSYNC_IN) begin
            line_buf[col_cur] <= cur_pair;
        end
    end

    // Per-channel 9-bit average of the current pixel and the one above; the sum cannot overflow.
    always_comb begin
        avg_pair = '0;
        chan_sum = '0;
        for (int c = 0; c < 6; c++) begin
            chan_sum = {1'b0, s1_cur_q[c*8 +: 8]} + {1'b0, prev_q[c*8 +: 8]} + ROUND_ADD;
            avg_pair[c*8 +: 8] = chan_sum[8:1];
        end
    end

    // Stage 2 selection: bypass or average, data forced to zero when no pair is valid.
    always_comb begin
        hsync_out_d = s1_valid_q;
        vsync_out_d = s1_vsync_q;
        done_d      = s1_valid_q && s1_last_q;
        data_out_d  = '0;
        if (s1_valid_q) begin
            data_out_d = s1_bypass_q ? s1_cur_q : avg_pair;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hsync_out_q <= 1'b0;
            vsync_out_q <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            hsync_out_q <= hsync_out_d;
            vsync_out_q <= vsync_out_d;
            done_q      <= done_d;
            data_out_q  <= data_out_d;
        end
    end

    assign HSYNC_OUT  = hsync_out_q;
    assign VSYNC_OUT  = vsync_out_q;
    assign FRAME_DONE = done_q;
    assign {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = data_out_q;

endmodule

// File: tb/tb_vertical_avg_filter.sv
// tb_vertical_avg_filter: directed vectors for vertical_avg_filter (WIDTH=4, HEIGHT=3).
// Two instances share the stimulus: one rounds, one truncates.
module tb_vertical_avg_filter;

    typedef struct {
        logic        rst;
        logic        vsync;
        logic        hsync;
        logic        en;
        logic [47:0] din;
        logic        exp_hsync;
        logic        exp_vsync;
        logic        exp_done;
        logic [47:0] exp_data;
        logic [47:0] exp_data_r0;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       vsync_in, hsync_in, en;
    logic [7:0] r0_in, g0_in, b0_in, r1_in, g1_in, b1_in;
    logic       vsync_out, hsync_out, frame_done;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic       vsync_out_t, hsync_out_t, frame_done_t;
    logic [7:0] r0_t, g0_t, b0_t, r1_t, g1_t, b1_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    vertical_avg_filter #(.WIDTH(4), .HEIGHT(3), .ROUND(1)) u_dut (
        .HCLK(clk), .HRESET(rst), .VSYNC_IN(vsync_in), .HSYNC_IN(hsync_in), .EN(en),
        .DATA_R0_IN(r0_in), .DATA_G0_IN(g0_in), .DATA_B0_IN(b0_in),
        .DATA_R1_IN(r1_in), .DATA_G1_IN(g1_in), .DATA_B1_IN(b1_in),
        .VSYNC_OUT(vsync_out), .HSYNC_OUT(hsync_out),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0),
        .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .FRAME_DONE(frame_done)
    );

    vertical_avg_filter #(.WIDTH(4), .HEIGHT(3), .ROUND(0)) u_dut_trunc (
        .HCLK(clk), .HRESET(rst), .VSYNC_IN(vsync_in), .HSYNC_IN(hsync_in), .EN(en),
        .DATA_R0_IN(r0_in), .DATA_G0_IN(g0_in), .DATA_B0_IN(b0_in),
        .DATA_R1_IN(r1_in), .DATA_G1_IN(g1_in), .DATA_B1_IN(b1_in),
        .VSYNC_OUT(vsync_out_t), .HSYNC_OUT(hsync_out_t),
        .DATA_R0(r0_t), .DATA_G0(g0_t), .DATA_B0(b0_t),
        .DATA_R1(r1_t), .DATA_G1(g1_t), .DATA_B1(b1_t),
        .FRAME_DONE(frame_done_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] rep(input logic [7:0] b);
        return {6{b}};
    endfunction

    function automatic void add_vec(input logic r, input logic v, input logic h, input logic e,
                                    input logic [47:0] d, input logic eh, input logic ev,
                                    input logic ed, input logic [47:0] ex, input logic [47:0] ex0);
        vec_t t;
        t.rst = r; t.vsync = v; t.hsync = h; t.en = e; t.din = d;
        t.exp_hsync = eh; t.exp_vsync = ev; t.exp_done = ed;
        t.exp_data = ex; t.exp_data_r0 = ex0;
        vecs.push_back(t);
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        vsync_in = v.vsync;
        hsync_in = v.hsync;
        en       = v.en;
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = v.din;
    endtask

    task automatic checkOutput(input string tag, input logic eh, input logic ev, input logic ed,
                               input logic [47:0] ex, input logic [47:0] ex0);
        logic [47:0] act, act0;
        act  = {r0, g0, b0, r1, g1, b1};
        act0 = {r0_t, g0_t, b0_t, r1_t, g1_t, b1_t};
        checks += 5;
        if (hsync_out !== eh) begin
            errors++;
            $display("[TB] FAIL %s hsync: got %0b expected %0b", tag, hsync_out, eh);
        end
        if (vsync_out !== ev) begin
            errors++;
            $display("[TB] FAIL %s vsync: got %0b expected %0b", tag, vsync_out, ev);
        end
        if (frame_done !== ed) begin
            errors++;
            $display("[TB] FAIL %s frame_done: got %0b expected %0b", tag, frame_done, ed);
        end
        if (act !== ex) begin
            errors++;
            $display("[TB] FAIL %s data: got %h expected %h", tag, act, ex);
        end
        if (act0 !== ex0) begin
            errors++;
            $display("[TB] FAIL %s data_trunc: got %h expected %h", tag, act0, ex0);
        end
    endtask

    initial begin
        vec_t idle;
        idle = '{rst: 1'b0, vsync: 1'b0, hsync: 1'b0, en: 1'b1, din: 48'h0,
                 exp_hsync: 1'b0, exp_vsync: 1'b0, exp_done: 1'b0,
                 exp_data: 48'h0, exp_data_r0: 48'h0};

        // Columns: rst vsync hsync en din | exp hsync vsync done data data_trunc (output 2 cycles after input)
        add_vec(0,0,1,1,rep(8'h40),          0,0,0,48'h0,48'h0);                 // 0  r0c0
        add_vec(0,0,1,1,rep(8'h40),          0,0,0,48'h0,48'h0);                 // 1  r0c1
        add_vec(0,0,0,1,48'h0,               1,0,0,rep(8'h40),rep(8'h40));       // 2
        add_vec(0,0,0,1,48'h0,               1,0,0,rep(8'h40),rep(8'h40));       // 3
        add_vec(0,1,1,1,rep(8'h10),          0,0,0,48'h0,48'h0);                 // 4  vsync r0c0
        add_vec(0,0,1,1,rep(8'h10),          0,0,0,48'h0,48'h0);                 // 5  r0c1
        add_vec(0,0,1,1,rep(8'h21),          1,1,0,rep(8'h10),rep(8'h10));       // 6  r1c0
        add_vec(0,0,1,1,48'h212223242526,    1,0,0,rep(8'h10),rep(8'h10));       // 7  r1c1
        add_vec(0,0,1,1,rep(8'hFF),          1,0,0,rep(8'h19),rep(8'h18));       // 8  r2c0
        add_vec(0,0,1,1,rep(8'hFF),          1,0,0,48'h19191A1A1B1B,48'h1819191A1A1B); // 9 r2c1
        add_vec(0,0,1,1,rep(8'h55),          1,0,0,rep(8'h90),rep(8'h90));       // 10 wrap r0c0
        add_vec(0,0,1,1,rep(8'hFF),          1,0,1,48'h909191929293,48'h909091919292); // 11 r0c1
        add_vec(0,0,0,1,48'h0,               1,0,0,rep(8'h55),rep(8'h55));       // 12 gap
        add_vec(0,0,1,1,rep(8'hFF),          1,0,0,rep(8'hFF),rep(8'hFF));       // 13 r1c0
        add_vec(0,0,1,1,rep(8'hFF),          0,0,0,48'h0,48'h0);                 // 14 r1c1
        add_vec(0,0,0,1,48'h0,               1,0,0,rep(8'hAA),rep(8'hAA));       // 15
        add_vec(0,0,1,1,rep(8'h80),          1,0,0,rep(8'hFF),rep(8'hFF));       // 16 r2c0
        add_vec(0,0,0,1,48'h0,               0,0,0,48'h0,48'h0);                 // 17
        add_vec(0,1,1,1,rep(8'h30),          1,0,0,rep(8'hC0),rep(8'hBF));       // 18 vsync mid-row
        add_vec(0,0,0,1,48'h0,               0,0,0,48'h0,48'h0);                 // 19
        add_vec(0,0,1,1,rep(8'h50),          1,1,0,rep(8'h30),rep(8'h30));       // 20 r0c1
        add_vec(0,0,1,0,rep(8'h70),          0,0,0,48'h0,48'h0);                 // 21 r1c0 bypass
        add_vec(0,0,1,1,rep(8'h11),          1,0,0,rep(8'h50),rep(8'h50));       // 22 r1c1
        add_vec(0,0,1,1,rep(8'h21),          1,0,0,rep(8'h70),rep(8'h70));       // 23 r2c0
        add_vec(0,0,0,1,48'h0,               1,0,0,rep(8'h31),rep(8'h30));       // 24
        add_vec(0,0,0,1,48'h0,               1,0,0,rep(8'h49),rep(8'h48));       // 25
        add_vec(0,1,1,1,rep(8'h60),          0,0,0,48'h0,48'h0);                 // 26 vsync r0c0
        add_vec(0,0,1,1,rep(8'h60),          0,0,0,48'h0,48'h0);                 // 27 r0c1
        add_vec(0,0,1,1,rep(8'h90),          1,1,0,rep(8'h60),rep(8'h60));       // 28 r1c0
        add_vec(1,0,0,1,48'h0,               0,0,0,48'h0,48'h0);                 // 29 reset mid-row
        add_vec(0,0,0,1,48'h0,               0,0,0,48'h0,48'h0);                 // 30
        add_vec(0,0,1,1,rep(8'h90),          0,0,0,48'h0,48'h0);                 // 31 r0c0 again
        add_vec(0,0,0,1,48'h0,               0,0,0,48'h0,48'h0);                 // 32
        add_vec(0,0,0,1,48'h0,               1,0,0,rep(8'h90),rep(8'h90));       // 33
        add_vec(0,0,0,1,48'h0,               0,0,0,48'h0,48'h0);                 // 34

        // Reset held for three cycles with live-looking input; outputs must stay zero.
        applyStimulus(idle);
        rst = 1'b1;
        hsync_in = 1'b1;
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = 48'hA5A5A5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_hold[%0d]", i), 0, 0, 0, 48'h0, 48'h0);
        end

        // Release with no valid input; outputs remain idle.
        @(posedge clk);
        #1;
        applyStimulus(idle);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_release[%0d]", i), 0, 0, 0, 48'h0, 48'h0);
            @(posedge clk);
            #1;
        end

        // Table: drive just after the rising edge, compare on the falling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec[%0d]", i), vecs[i].exp_hsync, vecs[i].exp_vsync,
                        vecs[i].exp_done, vecs[i].exp_data, vecs[i].exp_data_r0);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
